seq_mul: RTL and testbench
==========================

Name: seq_mul

Overview:
- Iterative shift-add multiplier, parametrised operand width N. Sequential successor to the team's fixed 4-bit array multiplier.
- Trades area for latency: one N-bit adder is reused for N cycles instead of N-1 adder rows.
- Uses valid/ready handshakes on both input and output, so it can sit directly in datapath pipelines.

Parameters:
N, 8, operand width in bits (N >= 2); product width is 2N
CW, $clog2(N), iteration counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
in_valid  in  1  operands a, b present
in_ready  out  1  block can accept operands
a  in  N  multiplicand
b  in  N  multiplier
out_valid  out  1  product p valid
out_ready  in  1  consumer accepts p
p  out  2N  product, registered
busy  out  1  high in BUSY or DONE

Behaviour:
- Single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, all internal registers 0.
- Reset asserted mid-operation: aborts immediately; the partial product is discarded.
- Internal registers: mcand[N-1:0]; acc[N:0] (upper half plus carry/sign); mq[N-1:0] (multiplier, shifts into lower product half); cnt[CW-1:0].
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: mcand<=a, mq<=b, acc<=0, cnt<=0, go to BUSY.
- BUSY (in_ready=0, in_valid ignored), one iteration per clock:
  - sum = acc + (mq[0] ? mcand : 0), computed N+1 bits wide.
  - {acc,mq} <= {sum,mq} >> 1, logical shift; the carry enters acc[N-1].
  - cnt increments each iteration.
  - When cnt==N-1, this iteration is the last: p<={sum,mq}>>1 truncated to 2N bits, go to DONE.
- DONE:
  - out_valid=1, in_ready=0; p held stable.
  - On out_ready: go to IDLE; out_valid drops next cycle; p keeps its value until the next result.
- Latency and throughput:
  - Input handshake at edge E0 gives out_valid=1 after edge E0+N.
  - With out_ready tied high, the minimum issue interval is N+2 cycles.
- out_ready held low in DONE: waits indefinitely, and p, out_valid are stable.
- Arithmetic: exact unsigned product, a*b < 2^(2N), so no overflow and no flag.
- Zero operands: still take N iterations. No early exit, so latency is fixed.
- a and b are sampled only at the accepting edge; later changes to a or b have no effect.

Optional Feature:
Macro SEQ_MUL_SIGNED_EN.
- Defined:
  - Adds input port tc (1 bit), sampled with the operands into a tc register.
  - tc=1 selects two's-complement multiply:
    - mcand is sign-extended to N+1 bits.
    - Iterations 0..N-2 add it when mq[0]=1.
    - Iteration N-1 subtracts it when mq[0]=1.
    - The shift is arithmetic, with sum[N] replicated.
  - p is the exact signed 2N-bit product.
  - tc=0 behaves exactly as the unsigned block.
- Undefined: no tc port; unsigned only. Latency is identical in both builds.

Test Plan:
- N=8, a=200, b=250, out_ready=1 -> out_valid exactly 8 edges after accept, p=16'hC350, in_ready low throughout BUSY/DONE.
- a=255, b=255 then a=0, b=173 back-to-back -> p=16'hFE01, then p=16'h0000, second accept no earlier than 10 cycles after the first.
- a=13, b=11, out_ready low for 5 cycles in DONE -> p=16'h008F held stable, out_valid high; in_valid pulses ignored; IDLE one cycle after out_ready rises.
- Start a=99, b=77, assert rst_n low at iteration 4 -> out_valid=0, p=0, in_ready=1 asynchronously; a fresh a=3, b=5 gives p=15.
- Change a, b every cycle during BUSY with a=6, b=7 accepted -> p=42 unaffected.
- SEQ_MUL_SIGNED_EN, tc=1:
  - a=8'hFD (-3), b=5 -> p=16'hFFF1.
  - a=8'h80, b=8'h80 -> p=16'h4000.
  - a=8'h7F, b=8'h80 -> p=16'hC080.
  - tc=0 with a=8'hFD, b=5 -> p=16'h04F1.

Source files
------------

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one N-bit adder reused over N cycles, valid/ready on both sides.
// Define SEQ_MUL_SIGNED_EN to add the tc input selecting two's-complement multiplication.
module seq_mul #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic           tc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   mq_q, mq_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] p_q, p_d;
  logic           sgn;

`ifdef SEQ_MUL_SIGNED_EN
  logic tc_q, tc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign sgn = tc_q;
`else
  assign sgn = 1'b0;
`endif

  // Datapath: one N+1-bit add (or subtract on the signed final step) per iteration.
  logic           last;
  logic [N:0]     mcand_ext;
  logic [N:0]     addend;
  logic [N:0]     sum;
  logic           fill;
  logic [N:0]     acc_shift;
  logic [N-1:0]   mq_shift;
  logic [2*N-1:0] product;

  assign last      = (cnt_q == CW'(N - 1));
  assign mcand_ext = {sgn & mcand_q[N-1], mcand_q};

  always_comb begin
    addend = '0;
    if (mq_q[0]) begin
      // The multiplier MSB carries weight -2^(N-1) in two's complement.
      if (sgn && last) begin
        addend = ~mcand_ext + (N + 1)'(1);
      end else begin
        addend = mcand_ext;
      end
    end
  end

  assign sum                   = acc_q + addend;
  assign fill                  = sgn & sum[N];
  assign {acc_shift, mq_shift} = {fill, sum, mq_q[N-1:1]};
  assign product               = {sum, mq_q[N-1:1]};

  // Control: IDLE accepts, BUSY iterates N times, DONE holds until the consumer takes p.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
`ifdef SEQ_MUL_SIGNED_EN
    tc_d    = tc_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SEQ_MUL_SIGNED_EN
          tc_d    = tc;
`endif
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_shift;
        mq_d  = mq_shift;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          p_d     = product;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign p         = p_q;

`ifndef SYNTHESIS
  a_hold_stalled : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(p)));

  a_ready_not_busy : assert property (@(posedge clk) disable iff (!rst_n)
    in_ready |-> !busy);
`endif

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: the driver queues hand-computed products, a monitor checks each
// accepted output. Signed vectors run only when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_mul;
  localparam int unsigned N = 8;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a         = '0;
  logic [N-1:0]   b         = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] p;
  logic           busy;
`ifdef SEQ_MUL_SIGNED_EN
  logic           tc        = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [2*N-1:0] exp_q[$];

  seq_mul #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SEQ_MUL_SIGNED_EN
    .tc        (tc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every output handshake pops one expected product.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", p);
      end else begin
        check("product", 32'(p), 32'(exp_q.pop_front()));
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv,
                      input logic [2*N-1:0] expv, output int acc_cyc);
    int g;
    g = 0;
    @(posedge clk); #1;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
    end
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int vcyc);
    int g;
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL %s_timeout actual=no_out_valid required=out_valid", name);
    end
    vcyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c2, vc, g;
    logic ok;

    // Reset values.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 200*250: latency and in_ready low during BUSY/DONE.
    send(8'd200, 8'd250, 16'hC350, c0);
    ok = 1'b1;
    g  = 0;
    @(negedge clk);
    while (!out_valid && g < 100) begin
      if (in_ready || !busy) ok = 1'b0;
      @(negedge clk);
      g++;
    end
    check("t1_ready_low_busy", 32'(ok), 32'd1);
    check("t1_latency", 32'(cyc - c0), 32'(N));
    check("t1_ready_low_done", 32'(in_ready), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd1);

    // Back-to-back: 255*255 then 0*173.
    send(8'd255, 8'd255, 16'hFE01, c1);
    send(8'd0, 8'd173, 16'h0000, c2);
    check("t2_issue_interval", 32'(c2 - c1), 32'(N + 2));
    wait_valid("t2", vc);

    // 13*11 with the consumer stalled for 5 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'd13, 8'd11, 16'h008F, c0);
    wait_valid("t3", vc);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_p", 32'(p), 32'h008F);
      check("t3_hold_not_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      a        = 8'd1;
      b        = 8'd1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_idle_ready", 32'(in_ready), 32'd1);
    check("t3_idle_valid", 32'(out_valid), 32'd0);
    check("t3_p_kept", 32'(p), 32'h008F);

    // 99*77 aborted by reset at iteration 4.
    send(8'd99, 8'd77, 16'h1DC7, c0);
    repeat (3) @(posedge clk);
    #3;
    check("t4_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_out_valid", 32'(out_valid), 32'd0);
    check("t4_rst_p", 32'(p), 32'd0);
    check("t4_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'd3, 8'd5, 16'd15, c0);
    wait_valid("t4", vc);

    // Operands changing during BUSY must not matter.
    send(8'd6, 8'd7, 16'd42, c0);
    for (int i = 0; i < N - 2; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk); #1;
    end
    wait_valid("t5", vc);

`ifdef SEQ_MUL_SIGNED_EN
    tc = 1'b1;
    send(8'hFD, 8'h05, 16'hFFF1, c0);
    wait_valid("s1", vc);
    send(8'h80, 8'h80, 16'h4000, c0);
    wait_valid("s2", vc);
    send(8'h7F, 8'h80, 16'hC080, c0);
    wait_valid("s3", vc);
    tc = 1'b0;
    send(8'hFD, 8'h05, 16'h04F1, c0);
    wait_valid("s4", vc);
`endif

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
